// File: rtl/data_mem.sv
// data_mem: parametrised byte/half/word data RAM with a valid/ready request channel and registered response.
// Define DATA_MEM_CLEAR_EN to zero every word after reset before the first request is accepted.
module data_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_busy
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  logic [AW-1:0] clr_idx;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t      state;
  logic [31:0] mem [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          range_err;
  logic          align_err;
  logic          err;
  logic          accept;
  logic [31:0]   cur_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   lane_wdata;
  logic [31:0]   wr_word;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both ends.
  assign off       = req_addr - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign range_err = ({2'b00, off} >= (34'(DEPTH) << 2));
  assign err       = range_err || align_err;

  assign req_ready = !rst && (state == IDLE) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;
  assign cur_word  = mem[idx];

  always_comb begin
    align_err = 1'b0;
    case (req_size)
      2'b01:   align_err = off[0];
      2'b10:   align_err = (off[1:0] != 2'b00);
      2'b11:   align_err = 1'b1;
      default: align_err = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = cur_word[{off[1:0], 3'b000} +: 8];
    ld_half = off[1] ? cur_word[31:16] : cur_word[15:0];
    case (req_size)
      2'b00:   ld_data = req_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = req_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = cur_word;
    endcase
  end

  // Replicate the right-aligned store data across lanes and let the byte enables pick.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = '0;
    case (req_size)
      2'b00: begin
        be         = 4'b0001 << off[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be         = 4'b1111;
        lane_wdata = req_wdata;
      end
      default: begin
        be         = 4'b0000;
        lane_wdata = '0;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? lane_wdata[8*i +: 8] : cur_word[8*i +: 8];
    end
  end

  always_comb begin
    mem_we    = accept && req_we && !err;
    mem_waddr = idx;
    mem_wdata = wr_word;
`ifdef DATA_MEM_CLEAR_EN
    if (!rst && state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DATA_MEM_CLEAR_EN
      state   <= CLEAR;
      clr_idx <= '0;
`else
      state   <= IDLE;
`endif
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
`ifdef DATA_MEM_CLEAR_EN
      if (state == CLEAR) begin
        clr_idx <= clr_idx + AW'(1);
        if (clr_idx == {AW{1'b1}}) state <= IDLE;
      end
`endif
      if (accept) begin
        resp_valid <= 1'b1;
        resp_rdata <= (req_we || err) ? 32'h0 : ld_data;
        resp_err   <= err;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

`ifdef DATA_MEM_CLEAR_EN
  assign init_busy = (state == CLEAR);
`else
  assign init_busy = 1'b0;
`endif

endmodule
